// File: rtl/rv32i_types.sv
// Shared types and geometry for the single-line data responder.
package rv32i_types;

   localparam int LINE_W = 256;
   localparam int BEAT_W = 64;
   localparam int BEATS  = 4;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      WB,
      FILL,
      RESP
   } dlr_state_t;

   // Byte-merge new_word into old_word; byte i is replaced when mbe[i] is set.
   function automatic logic [WORD_W-1:0] merge_word(
      input logic [WORD_W-1:0] old_word,
      input logic [WORD_W-1:0] new_word,
      input logic [3:0]        mbe
   );
      logic [WORD_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mbe[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/data_line_responder_line_burst_adaptor.sv
// line_burst_adaptor: tracks the current beat of a 4-beat burst, presents the
// outgoing beat of the line and the line with the incoming beat inserted.
module line_burst_adaptor
   import rv32i_types::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              active,
   input  logic              mem_resp,
   input  logic [LINE_W-1:0] line,
   input  logic [BEAT_W-1:0] mem_rdata,
   output logic [BEAT_W-1:0] beat_out,
   output logic [LINE_W-1:0] line_ins,
   output logic              last_beat
);

   logic [1:0]        beat_reg;
   logic [BEAT_W-1:0] beats [BEATS];

   // Beat counter advances only on responses inside a burst and wraps 3->0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat_reg <= 2'd0;
      end else if (active && mem_resp) begin
         beat_reg <= beat_reg + 2'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_beat
         assign beats[gi] = line[gi*BEAT_W +: BEAT_W];
         assign line_ins[gi*BEAT_W +: BEAT_W] =
            (beat_reg == 2'(gi)) ? mem_rdata : beats[gi];
      end
   endgenerate

   assign beat_out  = beats[beat_reg];
   assign last_beat = active && mem_resp && (beat_reg == 2'd3);

endmodule

// File: rtl/data_line_responder.sv
// data_line_responder: one-line write-back buffer between the core data port
// and a 4x64-bit burst memory port.
// Optional feature macro: DLR_PERF_COUNTERS_EN (adds hit_count/miss_count).
module data_line_responder
   import rv32i_types::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              data_read,
   input  logic              data_write,
   input  logic [3:0]        data_mbe,
   input  logic [31:0]       data_addr,
   input  logic [31:0]       data_wdata,
   output logic              data_resp,
   output logic [31:0]       data_rdata,
`ifdef DLR_PERF_COUNTERS_EN
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count,
`endif
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_addr,
   output logic [63:0]       mem_wdata,
   input  logic [63:0]       mem_rdata,
   input  logic              mem_resp
);

   dlr_state_t        state_reg, state_next;
   logic              valid_reg, valid_next;
   logic              dirty_reg, dirty_next;
   logic [26:0]       tag_reg, tag_next;
   logic [26:0]       miss_tag_reg, miss_tag_next;
   logic [LINE_W-1:0] line_reg, line_next;
   logic [31:0]       rdata_reg, rdata_next;
   logic [31:0]       mem_addr_reg, mem_addr_next;

   logic              req;
   logic [26:0]       req_tag;
   logic [2:0]        idx;
   logic [7:0]        word_base;
   logic              hit;
   logic              take_hit, take_miss;
   logic              do_access;
   logic [LINE_W-1:0] access_line;
   logic              burst_active;
   logic [BEAT_W-1:0] beat_out;
   logic [LINE_W-1:0] line_ins;
   logic              last_beat;
   logic              addr_unused;

   assign req         = data_read | data_write;
   assign req_tag     = data_addr[31:5];
   assign idx         = data_addr[4:2];
   assign word_base   = {idx, 5'b0};
   assign hit         = valid_reg && (tag_reg == req_tag);
   assign addr_unused = ^data_addr[1:0];

   assign burst_active = (state_reg == WB) || (state_reg == FILL);

   line_burst_adaptor u_adaptor (
      .clk       (clk),
      .reset     (reset),
      .active    (burst_active),
      .mem_resp  (mem_resp),
      .line      (line_reg),
      .mem_rdata (mem_rdata),
      .beat_out  (beat_out),
      .line_ins  (line_ins),
      .last_beat (last_beat)
   );

   // Burst strobes come straight from state so reset drops them immediately.
   assign mem_read   = (state_reg == FILL);
   assign mem_write  = (state_reg == WB);
   assign mem_wdata  = (state_reg == WB) ? beat_out : 64'd0;
   assign mem_addr   = mem_addr_reg;
   assign data_resp  = (state_reg == RESP);
   assign data_rdata = rdata_reg;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Line, tag, flags and output holding registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg    <= 1'b0;
         dirty_reg    <= 1'b0;
         tag_reg      <= '0;
         miss_tag_reg <= '0;
         line_reg     <= '0;
         rdata_reg    <= '0;
         mem_addr_reg <= '0;
      end else begin
         valid_reg    <= valid_next;
         dirty_reg    <= dirty_next;
         tag_reg      <= tag_next;
         miss_tag_reg <= miss_tag_next;
         line_reg     <= line_next;
         rdata_reg    <= rdata_next;
         mem_addr_reg <= mem_addr_next;
      end
   end

   // Next-state logic plus the word access shared by hits and fill completion.
   always_comb begin
      state_next    = state_reg;
      valid_next    = valid_reg;
      dirty_next    = dirty_reg;
      tag_next      = tag_reg;
      miss_tag_next = miss_tag_reg;
      line_next     = line_reg;
      rdata_next    = rdata_reg;
      mem_addr_next = mem_addr_reg;
      take_hit      = 1'b0;
      take_miss     = 1'b0;
      do_access     = 1'b0;
      access_line   = line_reg;

      case (state_reg)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  take_hit   = 1'b1;
                  do_access  = 1'b1;
                  state_next = RESP;
               end else begin
                  take_miss     = 1'b1;
                  miss_tag_next = req_tag;
                  if (valid_reg && dirty_reg) begin
                     mem_addr_next = {tag_reg, 5'b0};
                     state_next    = WB;
                  end else begin
                     mem_addr_next = {req_tag, 5'b0};
                     state_next    = FILL;
                  end
               end
            end
         end
         WB: begin
            if (last_beat) begin
               dirty_next    = 1'b0;
               mem_addr_next = {miss_tag_reg, 5'b0};
               state_next    = FILL;
            end
         end
         FILL: begin
            if (mem_resp) begin
               line_next = line_ins;
               if (last_beat) begin
                  tag_next    = req_tag;
                  valid_next  = 1'b1;
                  dirty_next  = 1'b0;
                  do_access   = 1'b1;
                  access_line = line_ins;
                  state_next  = RESP;
               end
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // A write wins when both read and write are asserted.
      if (do_access) begin
         if (data_write) begin
            line_next = access_line;
            line_next[word_base +: WORD_W] =
               merge_word(access_line[word_base +: WORD_W], data_wdata, data_mbe);
            dirty_next = 1'b1;
         end else begin
            rdata_next = access_line[word_base +: WORD_W];
         end
      end
   end

`ifdef DLR_PERF_COUNTERS_EN
   logic [31:0] hit_count_reg, miss_count_reg;

   // Saturating hit/miss counters, bumped when IDLE classifies a request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
      end else begin
         if (take_hit && (hit_count_reg != 32'hFFFF_FFFF)) begin
            hit_count_reg <= hit_count_reg + 32'd1;
         end
         if (take_miss && (miss_count_reg != 32'hFFFF_FFFF)) begin
            miss_count_reg <= miss_count_reg + 32'd1;
         end
      end
   end

   assign hit_count  = hit_count_reg;
   assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_data_line_responder.sv
// Directed self-checking bench for data_line_responder.
module tb_data_line_responder;

   logic        clk;
   logic        reset;
   logic        data_read;
   logic        data_write;
   logic [3:0]  data_mbe;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_resp;
   logic [31:0] data_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_resp;
`ifdef DLR_PERF_COUNTERS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [63:0] fill_a [4];
   logic [63:0] fill_b [4];
   logic [63:0] wb_exp [4];

   data_line_responder dut (
      .clk        (clk),
      .reset      (reset),
      .data_read  (data_read),
      .data_write (data_write),
      .data_mbe   (data_mbe),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_resp  (data_resp),
      .data_rdata (data_rdata),
`ifdef DLR_PERF_COUNTERS_EN
      .hit_count  (hit_count),
      .miss_count (miss_count),
`endif
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_resp   (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      data_read = 1'b0; data_write = 1'b0; data_mbe = 4'h0;
      data_addr = 32'h0; data_wdata = 32'h0;
      mem_rdata = 64'h0; mem_resp = 1'b0;
      tick();
      tick();
      checks++;
      if ({data_resp, mem_read, mem_write} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes: got %b expected 000", {data_resp, mem_read, mem_write});
      end
      checks++;
      if (data_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 64'h0) begin
         errors++;
         $display("FAIL reset_buses: got rdata=%h addr=%h wdata=%h expected zeros",
                  data_rdata, mem_addr, mem_wdata);
      end
`ifdef DLR_PERF_COUNTERS_EN
      checks++;
      if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: got hit=%0d miss=%0d expected 0 0", hit_count, miss_count);
      end
`endif
      reset = 1'b0;
      tick();
      $display("reset: done");
   endtask

   task automatic test_clean_miss();
      data_read = 1'b1; data_addr = 32'h0000_0100;
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h100 || data_resp !== 1'b0) begin
         errors++;
         $display("FAIL clean_miss_start: got rd=%b wr=%b addr=%h resp=%b expected 1 0 00000100 0",
                  mem_read, mem_write, mem_addr, data_resp);
      end
      for (int b = 0; b < 4; b++) begin
         mem_rdata = fill_a[b];
         mem_resp  = 1'b1;
         tick();
         mem_resp  = 1'b0;
         if (b < 3) begin
            checks++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h100 || data_resp !== 1'b0) begin
               errors++;
               $display("FAIL clean_miss_beat%0d: got rd=%b wr=%b addr=%h resp=%b expected 1 0 00000100 0",
                        b, mem_read, mem_write, mem_addr, data_resp);
            end
         end
      end
      checks++;
      if (data_resp !== 1'b1 || data_rdata !== 32'h1111_1110 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL clean_miss_resp: got resp=%b rdata=%h rd=%b expected 1 11111110 0",
                  data_resp, data_rdata, mem_read);
      end
      data_read = 1'b0;
      tick();
      checks++;
      if (data_resp !== 1'b0) begin
         errors++;
         $display("FAIL clean_miss_resp_width: got resp=%b expected 0", data_resp);
      end
      // A stray response while idle must not start anything.
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || data_resp !== 1'b0) begin
         errors++;
         $display("FAIL idle_mem_resp: got rd=%b wr=%b resp=%b expected 0 0 0",
                  mem_read, mem_write, data_resp);
      end
      $display("clean miss read 0x100: rdata=%h", data_rdata);
   endtask

   task automatic test_hit_read();
      data_read = 1'b1; data_addr = 32'h0000_011C;
      tick();
      checks++;
      if (data_resp !== 1'b1 || data_rdata !== 32'h4444_4444 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL hit_read_11c: got resp=%b rdata=%h rd=%b wr=%b expected 1 44444444 0 0",
                  data_resp, data_rdata, mem_read, mem_write);
      end
      data_read = 1'b0;
      tick();
      checks++;
      if (data_resp !== 1'b0) begin
         errors++;
         $display("FAIL hit_read_resp_width: got resp=%b expected 0", data_resp);
      end
      $display("hit read 0x11C: rdata=%h", data_rdata);
   endtask

   task automatic test_write_hit();
      data_write = 1'b1; data_addr = 32'h0000_0108;
      data_mbe = 4'b0011; data_wdata = 32'hAABB_CCDD;
      tick();
      checks++;
      if (data_resp !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL write_hit_108: got resp=%b rd=%b wr=%b expected 1 0 0",
                  data_resp, mem_read, mem_write);
      end
      data_write = 1'b0; data_mbe = 4'h0;
      tick();
      data_read = 1'b1;
      tick();
      checks++;
      if (data_resp !== 1'b1 || data_rdata !== 32'h2222_CCDD) begin
         errors++;
         $display("FAIL readback_108: got resp=%b rdata=%h expected 1 2222ccdd", data_resp, data_rdata);
      end
      data_read = 1'b0;
      tick();
      $display("write hit 0x108 then read: rdata=%h", data_rdata);
   endtask

   task automatic test_dirty_miss();
      data_read = 1'b1; data_addr = 32'h0000_0200;
      tick();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h100 || mem_wdata !== wb_exp[k]) begin
            errors++;
            $display("FAIL wb_beat%0d: got wr=%b rd=%b addr=%h wdata=%h expected 1 0 00000100 %h",
                     k, mem_write, mem_read, mem_addr, mem_wdata, wb_exp[k]);
         end
         mem_resp = 1'b1;
         tick();
         mem_resp = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h200) begin
            errors++;
            $display("FAIL fill_after_wb_beat%0d: got rd=%b wr=%b addr=%h expected 1 0 00000200",
                     k, mem_read, mem_write, mem_addr);
         end
         mem_rdata = fill_b[k];
         mem_resp  = 1'b1;
         tick();
         mem_resp  = 1'b0;
      end
      checks++;
      if (data_resp !== 1'b1 || data_rdata !== 32'hA000_0000 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL dirty_miss_resp: got resp=%b rdata=%h rd=%b expected 1 a0000000 0",
                  data_resp, data_rdata, mem_read);
      end
      data_read = 1'b0;
      tick();
`ifdef DLR_PERF_COUNTERS_EN
      checks++;
      if (hit_count !== 32'd3 || miss_count !== 32'd2) begin
         errors++;
         $display("FAIL perf_counts: got hit=%0d miss=%0d expected 3 2", hit_count, miss_count);
      end
`endif
      $display("dirty miss read 0x200: rdata=%h", data_rdata);
   endtask

   task automatic test_reset_mid_fill();
      data_read = 1'b1; data_addr = 32'h0000_0300;
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h300) begin
         errors++;
         $display("FAIL clean_victim_fill: got rd=%b wr=%b addr=%h expected 1 0 00000300",
                  mem_read, mem_write, mem_addr);
      end
      for (int b = 0; b < 2; b++) begin
         mem_rdata = fill_a[b];
         mem_resp  = 1'b1;
         tick();
         mem_resp  = 1'b0;
      end
      mem_rdata = fill_a[2];
      mem_resp  = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_drop: got rd=%b wr=%b expected 0 0", mem_read, mem_write);
      end
      mem_resp  = 1'b0;
      data_read = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      data_read = 1'b1; data_addr = 32'h0000_0200;
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL post_reset_miss: got rd=%b wr=%b addr=%h expected 1 0 00000200",
                  mem_read, mem_write, mem_addr);
      end
      for (int b = 0; b < 4; b++) begin
         mem_rdata = fill_b[b];
         mem_resp  = 1'b1;
         tick();
         mem_resp  = 1'b0;
      end
      checks++;
      if (data_resp !== 1'b1 || data_rdata !== 32'hA000_0000) begin
         errors++;
         $display("FAIL post_reset_resp: got resp=%b rdata=%h expected 1 a0000000", data_resp, data_rdata);
      end
`ifdef DLR_PERF_COUNTERS_EN
      checks++;
      if (hit_count !== 32'd0 || miss_count !== 32'd1) begin
         errors++;
         $display("FAIL perf_after_reset: got hit=%0d miss=%0d expected 0 1", hit_count, miss_count);
      end
`endif
      data_read = 1'b0;
      tick();
      $display("reset mid fill then read 0x200: rdata=%h", data_rdata);
   endtask

   initial begin
      fill_a[0] = 64'h1111_1111_1111_1110;
      fill_a[1] = 64'h2222_2222_2222_2221;
      fill_a[2] = 64'h3333_3333_3333_3332;
      fill_a[3] = 64'h4444_4444_4444_4443;
      fill_b[0] = 64'hB000_0000_A000_0000;
      fill_b[1] = 64'hB000_0001_A000_0001;
      fill_b[2] = 64'hB000_0002_A000_0002;
      fill_b[3] = 64'hB000_0003_A000_0003;
      wb_exp[0] = 64'h1111_1111_1111_1110;
      wb_exp[1] = 64'h2222_2222_2222_CCDD;
      wb_exp[2] = 64'h3333_3333_3333_3332;
      wb_exp[3] = 64'h4444_4444_4444_4443;

      test_reset();
      test_clean_miss();
      test_hit_read();
      test_write_hit();
      test_dirty_miss();
      test_reset_mid_fill();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
